// File: rtl/led_event_indicator_pkg.sv
// Shared types and helpers for the LED event indicator: channel state encoding
// and the per-channel counter width calculation.
package led_event_indicator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } chan_state_e;

    // Counter must hold ON_CYCLES-1 and OFF_CYCLES-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned on_cycles,
                                              input int unsigned off_cycles);
        int unsigned mx;
        mx = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return (mx > 1) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/led_flash_channel.sv
// One LED channel: stretches an event into a fixed ON flash followed by a
// dark GAP, with a single-deep pending flag for events that arrive meanwhile.
module led_flash_channel
    import led_event_indicator_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 12500000,
    parameter int unsigned OFF_CYCLES = 6250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic evt_i,
    input  logic pwm_on_i,
    output logic led_o,
    output logic busy_o
);

    localparam int unsigned CNT_W = cnt_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             led_d, busy_d;

    // Next-state, counter and pending logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (evt_i) begin
                    state_d = ST_ON;
                    cnt_d   = ON_LOAD;
                end
            end
            ST_ON: begin
                if (evt_i) begin
                    pend_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = OFF_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                // An event on the last gap cycle is taken directly, not queued.
                if (cnt_q == '0) begin
                    if (pend_q || evt_i) begin
                        state_d = ST_ON;
                        cnt_d   = ON_LOAD;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (evt_i) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
        led_d  = (state_d == ST_ON) && pwm_on_i;
        busy_d = (state_d != ST_IDLE) || pend_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            led_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            led_o   <= led_d;
            busy_o  <= busy_d;
        end
    end

endmodule

// File: rtl/led_event_indicator.sv
// Turns single-cycle events into human-visible LED flashes on N_LED channels,
// with a shared free-running PWM counter setting brightness.
module led_event_indicator
    import led_event_indicator_pkg::*;
#(
    parameter int unsigned N_LED      = 4,
    parameter int unsigned ON_CYCLES  = 12500000,
    parameter int unsigned OFF_CYCLES = 6250000,
    parameter int unsigned PWM_BITS   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_LED-1:0]    evt,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [N_LED-1:0]    led,
    output logic [N_LED-1:0]    busy
);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_on_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        end
    end

    // All-ones brightness forces fully on, closing the one-count gap of the compare.
    assign pwm_on_c = (brightness == {PWM_BITS{1'b1}}) || (pwm_cnt_q < brightness);

    for (genvar g = 0; g < N_LED; g++) begin : g_chan
        led_flash_channel #(
            .ON_CYCLES (ON_CYCLES),
            .OFF_CYCLES(OFF_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .evt_i   (evt[g]),
            .pwm_on_i(pwm_on_c),
            .led_o   (led[g]),
            .busy_o  (busy[g])
        );
    end

endmodule

// File: tb/tb_led_event_indicator.sv
// Directed bench for led_event_indicator with N_LED=2, ON=8, OFF=4, PWM_BITS=3.
// "Cycle c" is the interval after rising edge c-1; edge 0 is the reset edge.
module tb_led_event_indicator;

    logic       clk;
    logic       rst_n;
    logic [1:0] evt;
    logic [2:0] brightness;
    logic [1:0] led;
    logic [1:0] busy;

    int checks;
    int errors;

    led_event_indicator #(
        .N_LED     (2),
        .ON_CYCLES (8),
        .OFF_CYCLES(4),
        .PWM_BITS  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt       (evt),
        .brightness(brightness),
        .led       (led),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic inr(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Reset edge becomes edge 0 of the next scenario.
    task automatic do_reset();
        rst_n = 1'b0;
        evt   = 2'b00;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        evt        = 2'b00;
        brightness = 3'd7;

        // Reset state
        step();
        do_reset();
        chk("rst led0", 1, led[0], 1'b0);
        chk("rst led1", 1, led[1], 1'b0);
        chk("rst busy0", 1, busy[0], 1'b0);
        chk("rst busy1", 1, busy[1], 1'b0);

        // Single event at edge 10
        brightness = 3'd7;
        for (int c = 1; c <= 26; c++) begin
            evt = (c == 10) ? 2'b01 : 2'b00;
            step();
            chk("single led0", c + 1, led[0], inr(c + 1, 11, 18));
            chk("single busy0", c + 1, busy[0], inr(c + 1, 11, 22));
            chk("single led1", c + 1, led[1], 1'b0);
            chk("single busy1", c + 1, busy[1], 1'b0);
        end

        // Pending collapse: events at 10, 12, 14 give exactly two flashes
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            evt = (c == 10 || c == 12 || c == 14) ? 2'b01 : 2'b00;
            step();
            chk("collapse led0", c + 1, led[0], inr(c + 1, 11, 18) || inr(c + 1, 23, 30));
            chk("collapse busy0", c + 1, busy[0], inr(c + 1, 11, 34));
        end

        // Event on the final GAP cycle is consumed without leaving a pending flag
        do_reset();
        for (int c = 1; c <= 48; c++) begin
            evt = (c == 10 || c == 22) ? 2'b01 : 2'b00;
            step();
            chk("lastgap led0", c + 1, led[0], inr(c + 1, 11, 18) || inr(c + 1, 23, 30));
            chk("lastgap busy0", c + 1, busy[0], inr(c + 1, 11, 34));
        end

        // Held evt[1] with brightness 2: 8-on/4-off envelope gated by pwm_cnt in {0,1}
        do_reset();
        brightness = 3'd2;
        for (int c = 1; c <= 40; c++) begin
            evt = 2'b10;
            step();
            chk("held led1", c + 1, led[1], (((c - 1) % 12) < 8) && (((c - 1) % 8) < 2));
            chk("held busy1", c + 1, busy[1], 1'b1);
            chk("held led0", c + 1, led[0], 1'b0);
        end

        // Brightness 0: dark LED but normal busy timing
        do_reset();
        brightness = 3'd0;
        for (int c = 1; c <= 26; c++) begin
            evt = (c == 10) ? 2'b01 : 2'b00;
            step();
            chk("dark led0", c + 1, led[0], 1'b0);
            chk("dark busy0", c + 1, busy[0], inr(c + 1, 11, 22));
        end

        // Reset mid-flash with a pending event: everything aborts, no later flash
        do_reset();
        brightness = 3'd7;
        for (int c = 1; c <= 40; c++) begin
            evt   = (c == 10 || c == 12) ? 2'b01 : 2'b00;
            rst_n = (c == 14) ? 1'b0 : 1'b1;
            step();
            chk("midrst led0", c + 1, led[0], inr(c + 1, 11, 14));
            chk("midrst busy0", c + 1, busy[0], inr(c + 1, 11, 14));
        end
        rst_n = 1'b1;
        evt   = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
